zap_dmem_wb_bridge: RTL and testbench

Data-side memory adapter between the zap_top load/store port and a Wishbone B3 classic bus. It converts one core request (read or write; word, byte or halfword, signed or unsigned) into a single Wishbone cycle. It drives stall back to the core until the cycle completes and returns aligned, extended load data. It replaces the behavioural cache model on the data path, and it signals aborts for bus errors, timeouts and misaligned halfwords.

---
 rtl/zap_dmem_wb_bridge_pkg.sv | 42 ++++
 rtl/zap_load_align.sv | 33 +++
 rtl/zap_dmem_wb_bridge.sv | 163 ++++++++++++++++
 tb/tb_zap_dmem_wb_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_dmem_wb_bridge_pkg.sv
// rtl/zap_dmem_wb_bridge_pkg.sv - shared encodings and lane helpers for the data-side Wishbone bridge
package zap_dmem_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WID_WORD = 2'd0,
        WID_HALF = 2'd1,
        WID_BYTE = 2'd2
    } width_t;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;

    function automatic logic [3:0] lane_sel(input width_t w, input logic [1:0] a);
        logic [3:0] sel;
        case (w)
            WID_BYTE: sel = SEL_BYTE0 << a;
            WID_HALF: sel = a[1] ? SEL_HALF_HI : SEL_HALF_LO;
            default:  sel = SEL_WORD;
        endcase
        return sel;
    endfunction

    // Sub-word stores replicate the low bits so every selected lane carries the data.
    function automatic logic [31:0] store_data(input width_t w, input logic [31:0] wr);
        logic [31:0] d;
        case (w)
            WID_BYTE: d = {4{wr[7:0]}};
            WID_HALF: d = {2{wr[15:0]}};
            default:  d = wr;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/zap_load_align.sv
// rtl/zap_load_align.sv - extracts and extends load data from a 32-bit little-endian bus word
module zap_load_align
    import zap_dmem_wb_bridge_pkg::*;
(
    input  logic [31:0] dat,
    input  logic [1:0]  a,
    input  width_t      width,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = dat[{a, 3'b000} +: 8];
        lane_h = a[1] ? dat[31:16] : dat[15:0];
        case (width)
            WID_BYTE: result = {{24{sgn & lane_b[7]}}, lane_b};
            WID_HALF: result = {{16{sgn & lane_h[15]}}, lane_h};
            default: begin
                // Unaligned word loads rotate right by 8*a, matching ARMv4 behaviour.
                case (a)
                    2'd1:    result = {dat[7:0],  dat[31:8]};
                    2'd2:    result = {dat[15:0], dat[31:16]};
                    2'd3:    result = {dat[23:0], dat[31:24]};
                    default: result = dat;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/zap_dmem_wb_bridge.sv
// rtl/zap_dmem_wb_bridge.sv - converts one core load/store request into one Wishbone B3 classic cycle
module zap_dmem_wb_bridge
    import zap_dmem_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_address,
    input  logic        i_unsigned_byte_en,
    input  logic        i_signed_byte_en,
    input  logic        i_unsigned_halfword_en,
    input  logic        i_signed_halfword_en,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_stall,
    output logic        o_abort,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t           state;
    width_t           width_q;
    logic             sign_q;
    logic [1:0]       a_q;
    logic [TMO_W-1:0] cnt;
    logic             flushed;

    logic             req;
    width_t           req_width;
    logic             req_sign;
    logic             misalign;
    logic             tmo_hit;
    logic [31:0]      load_data;

    assign req = i_read_en | i_write_en;

    always_comb begin
        req_width = WID_WORD;
        req_sign  = 1'b0;
        if (i_unsigned_byte_en | i_signed_byte_en) begin
            req_width = WID_BYTE;
            req_sign  = i_signed_byte_en;
        end else if (i_unsigned_halfword_en | i_signed_halfword_en) begin
            req_width = WID_HALF;
            req_sign  = i_signed_halfword_en;
        end
    end

    assign misalign = (req_width == WID_HALF) && i_address[0];
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TMO_W'(TMO_LAST));

    always_comb begin
        o_stall = 1'b0;
        if (!i_reset) begin
            case (state)
                ST_IDLE: o_stall = req;
                ST_BUS:  o_stall = 1'b1;
                default: o_stall = 1'b0;
            endcase
        end
    end

    zap_load_align u_load_align (
        .dat    (i_wb_dat),
        .a      (a_q),
        .width  (width_q),
        .sgn    (sign_q),
        .result (load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            width_q   <= WID_WORD;
            sign_q    <= 1'b0;
            a_q       <= 2'd0;
            cnt       <= '0;
            flushed   <= 1'b0;
            o_rd_data <= 32'd0;
            o_abort   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_adr  <= 32'd0;
            o_wb_sel  <= 4'd0;
            o_wb_dat  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_abort <= 1'b0;
                    if (req && misalign) begin
                        o_abort <= 1'b1;
                        state   <= ST_DONE;
                    end else if (req) begin
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= i_write_en;
                        o_wb_adr <= {i_address[31:2], 2'b00};
                        o_wb_sel <= lane_sel(req_width, i_address[1:0]);
                        o_wb_dat <= store_data(req_width, i_wr_data);
                        width_q  <= req_width;
                        sign_q   <= req_sign;
                        a_q      <= i_address[1:0];
                        cnt      <= '0;
                        flushed  <= 1'b0;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    cnt <= cnt + 1'b1;
                    if (!req) begin
                        flushed <= 1'b1;
                    end
                    // A withdrawn request lets the cycle finish but skips the DONE pulse.
                    if (i_wb_err || (!i_wb_ack && tmo_hit)) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (flushed || !req) begin
                            state <= ST_IDLE;
                        end else begin
                            o_abort <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (flushed || !req) begin
                            state <= ST_IDLE;
                        end else begin
                            if (!o_wb_we) begin
                                o_rd_data <= load_data;
                            end
                            o_abort <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    o_abort <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    o_abort <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_dmem_wb_bridge.sv
// tb/tb_zap_dmem_wb_bridge.sv - directed self-checking bench for the data-side Wishbone bridge
module tb_zap_dmem_wb_bridge;

    logic        clk;
    logic        reset;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic        ub, sb, uh, sh;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        abort;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_adr;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [31:0] cap_dat;
    int          stall_cnt;
    int          cyc_cnt;
    logic        got_done;
    logic        done_abort;
    logic [31:0] done_rd;
    logic        done_cyc;
    logic        post_abort;

    localparam logic [3:0] K_WORD = 4'b0000;
    localparam logic [3:0] K_UB   = 4'b1000;
    localparam logic [3:0] K_SB   = 4'b0100;
    localparam logic [3:0] K_UH   = 4'b0010;
    localparam logic [3:0] K_SH   = 4'b0001;

    zap_dmem_wb_bridge #(
        .TIMEOUT_CYCLES (4),
        .TMO_W          (8)
    ) dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_read_en              (read_en),
        .i_write_en             (write_en),
        .i_address              (address),
        .i_unsigned_byte_en     (ub),
        .i_signed_byte_en       (sb),
        .i_unsigned_halfword_en (uh),
        .i_signed_halfword_en   (sh),
        .i_wr_data              (wr_data),
        .o_rd_data              (rd_data),
        .o_stall                (stall),
        .o_abort                (abort),
        .o_wb_cyc               (wb_cyc),
        .o_wb_stb               (wb_stb),
        .o_wb_we                (wb_we),
        .o_wb_adr               (wb_adr),
        .o_wb_sel               (wb_sel),
        .o_wb_dat               (wb_dat),
        .i_wb_dat               (wb_rdat),
        .i_wb_ack               (wb_ack),
        .i_wb_err               (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and plays a bus slave that answers on BUS cycle ack_at (-1 = never).
    task automatic run_access(input string tag, input logic wr, input logic rd, input logic [3:0] kind,
                              input logic [31:0] addr, input logic [31:0] wdata, input int ack_at,
                              input logic use_err, input logic [31:0] bus_rdata);
        write_en = wr;
        read_en  = rd;
        {ub, sb, uh, sh} = kind;
        address  = addr;
        wr_data  = wdata;
        stall_cnt = 0;
        cyc_cnt   = 0;
        got_done  = 1'b0;
        cap_adr = 32'hx; cap_sel = 4'hx; cap_we = 1'bx; cap_dat = 32'hx;
        #1;
        for (int i = 0; i < 20 && !got_done; i++) begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (!stall) begin
                got_done = 1'b1;
            end else begin
                if (wb_cyc) begin
                    if (cyc_cnt == 0) begin
                        cap_adr = wb_adr; cap_sel = wb_sel; cap_we = wb_we; cap_dat = wb_dat;
                    end
                    if (cyc_cnt == ack_at) begin
                        if (use_err) wb_err = 1'b1;
                        else begin
                            wb_ack  = 1'b1;
                            wb_rdat = bus_rdata;
                        end
                    end
                    cyc_cnt++;
                end
                stall_cnt++;
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_done_reached"}, 32'(got_done), 32'd1);
        done_abort = abort;
        done_rd    = rd_data;
        done_cyc   = wb_cyc;
        read_en = 1'b0; write_en = 1'b0; {ub, sb, uh, sh} = 4'b0;
        #1;
        tick();
        post_abort = abort;
    endtask

    initial begin
        reset = 1'b1;
        read_en = 1'b0; write_en = 1'b0; address = 32'd0;
        {ub, sb, uh, sh} = 4'b0; wr_data = 32'd0;
        wb_rdat = 32'd0; wb_ack = 1'b0; wb_err = 1'b0;
        tick(); tick();
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_dat", wb_dat, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        read_en = 1'b1; #1;
        check("rst_stall", 32'(stall), 32'd0);
        read_en = 1'b0;
        reset = 1'b0;
        tick();

        run_access("wwr", 1, 0, K_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 32'h0);
        check("wwr_adr", cap_adr, 32'h0000_0100);
        check("wwr_sel", 32'(cap_sel), 32'hF);
        check("wwr_we", 32'(cap_we), 32'd1);
        check("wwr_dat", cap_dat, 32'hDEAD_BEEF);
        check("wwr_stall_cycles", 32'(stall_cnt), 32'd4);
        check("wwr_abort", 32'(done_abort), 32'd0);
        check("wwr_cyc_dropped", 32'(done_cyc), 32'd0);

        run_access("sbld", 0, 1, K_SB, 32'h0000_0203, 32'h0, 0, 0, 32'h8011_2233);
        check("sbld_adr", cap_adr, 32'h0000_0200);
        check("sbld_sel", 32'(cap_sel), 32'h8);
        check("sbld_rd", done_rd, 32'hFFFF_FF80);
        check("sbld_abort", 32'(done_abort), 32'd0);

        run_access("ubld", 0, 1, K_UB, 32'h0000_0203, 32'h0, 0, 0, 32'h8011_2233);
        check("ubld_rd", done_rd, 32'h0000_0080);
        check("ubld_stall_cycles", 32'(stall_cnt), 32'd2);

        run_access("uhld", 0, 1, K_UH, 32'h0000_0202, 32'h0, 1, 0, 32'hBEEF_1234);
        check("uhld_sel", 32'(cap_sel), 32'hC);
        check("uhld_rd", done_rd, 32'h0000_BEEF);

        run_access("shld", 0, 1, K_SH, 32'h0000_0200, 32'h0, 0, 0, 32'h0000_8001);
        check("shld_sel", 32'(cap_sel), 32'h3);
        check("shld_rd", done_rd, 32'hFFFF_8001);

        run_access("mis", 0, 1, K_SH, 32'h0000_0201, 32'h0, 0, 0, 32'h0);
        check("mis_no_cyc", 32'(cyc_cnt), 32'd0);
        check("mis_abort", 32'(done_abort), 32'd1);
        check("mis_stall_cycles", 32'(stall_cnt), 32'd1);
        check("mis_abort_cleared", 32'(post_abort), 32'd0);
        check("mis_rd_kept", done_rd, 32'hFFFF_8001);

        run_access("bst", 1, 0, K_UB, 32'h0000_0102, 32'h1234_56A5, 0, 0, 32'h0);
        check("bst_sel", 32'(cap_sel), 32'h4);
        check("bst_dat", cap_dat, 32'hA5A5_A5A5);

        // Read and write together with halfword width: the store must win.
        run_access("hst", 1, 1, K_UH, 32'h0000_0102, 32'hFFFF_1234, 0, 0, 32'h0);
        check("hst_sel", 32'(cap_sel), 32'hC);
        check("hst_dat", cap_dat, 32'h1234_1234);
        check("hst_we", 32'(cap_we), 32'd1);
        check("hst_rd_kept", done_rd, 32'hFFFF_8001);

        run_access("wld", 0, 1, K_WORD, 32'h0000_0301, 32'h0, 0, 0, 32'h4433_2211);
        check("wld_adr", cap_adr, 32'h0000_0300);
        check("wld_rd", done_rd, 32'h1144_3322);

        run_access("err", 0, 1, K_WORD, 32'h0000_0400, 32'h0, 0, 1, 32'hCAFE_F00D);
        check("err_abort", 32'(done_abort), 32'd1);
        check("err_rd_kept", done_rd, 32'h1144_3322);
        check("err_abort_cleared", 32'(post_abort), 32'd0);

        run_access("tmo", 0, 1, K_WORD, 32'h0000_0500, 32'h0, -1, 0, 32'h0);
        check("tmo_bus_cycles", 32'(cyc_cnt), 32'd4);
        check("tmo_abort", 32'(done_abort), 32'd1);
        check("tmo_cyc_dropped", 32'(done_cyc), 32'd0);
        check("tmo_rd_kept", done_rd, 32'h1144_3322);

        // Stray ack while idle must do nothing.
        wb_ack = 1'b1; wb_rdat = 32'h5555_5555;
        tick();
        wb_ack = 1'b0;
        check("stray_cyc", 32'(wb_cyc), 32'd0);
        check("stray_rd", rd_data, 32'h1144_3322);
        check("stray_abort", 32'(abort), 32'd0);

        // Flush: request withdrawn during BUS, ack still completes the cycle.
        read_en = 1'b1; address = 32'h0000_0700;
        tick();
        check("flush_cyc", 32'(wb_cyc), 32'd1);
        read_en = 1'b0;
        wb_ack = 1'b1; wb_rdat = 32'h1234_5678;
        #1;
        check("flush_stall_bus", 32'(stall), 32'd1);
        tick();
        wb_ack = 1'b0;
        check("flush_cyc_dropped", 32'(wb_cyc), 32'd0);
        check("flush_no_abort", 32'(abort), 32'd0);
        check("flush_rd_kept", rd_data, 32'h1144_3322);
        tick();
        check("flush_idle_abort", 32'(abort), 32'd0);

        // Reset in the second BUS cycle, then a late ack.
        read_en = 1'b1; address = 32'h0000_0600;
        tick();
        tick();
        check("rstbus_cyc_before", 32'(wb_cyc), 32'd1);
        reset = 1'b1;
        tick();
        check("rstbus_cyc", 32'(wb_cyc), 32'd0);
        check("rstbus_stb", 32'(wb_stb), 32'd0);
        check("rstbus_stall", 32'(stall), 32'd0);
        reset = 1'b0; read_en = 1'b0;
        wb_ack = 1'b1; wb_rdat = 32'h9999_9999;
        tick();
        wb_ack = 1'b0;
        check("late_ack_cyc", 32'(wb_cyc), 32'd0);
        check("late_ack_rd", rd_data, 32'd0);
        check("late_ack_abort", 32'(abort), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
